// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single program/data RAM between the CPU (fixed
// priority reads) and the program loader (valid/ready write beats).
// A saturating starvation counter lets a denied loader preempt the CPU, and
// a bounded burst counter hands the RAM back to the CPU after MAX_BURST
// consecutive loader beats. While the CPU is halted the loader is unbounded.
module ram_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  // CPU read port
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_hlt,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Program loader write port
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [SW-1:0] r_starve_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          r_cpu_rvalid;

  logic w_starved;
  logic w_in_burst;
  logic w_ld_win;

  // A burst in progress keeps the loader ahead of the CPU until it reaches
  // MAX_BURST beats; at the limit the CPU gets the next cycle.
  assign w_starved  = (r_starve_cnt == SW'(STARVE_LIM));
  assign w_in_burst = (r_burst_cnt != '0) && (r_burst_cnt < BW'(MAX_BURST));

  // Reset masks both grants so nothing is written or read during rst.
  assign w_ld_win = ld_valid & ~rst &
                    (~cpu_req | cpu_hlt | w_starved | w_in_burst);

  assign ld_ready   = w_ld_win;
  assign cpu_gnt    = cpu_req & ~w_ld_win & ~rst;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = ram_rdata;

  // The loader drives the RAM only on a winning cycle; otherwise the CPU
  // address is presented as a read with the write data parked at zero.
  assign ram_addr  = w_ld_win ? ld_addr : cpu_addr;
  assign ram_we    = w_ld_win;
  assign ram_wdata = w_ld_win ? ld_data : '0;

  // Starvation counter: cleared on an accepted beat, counts denied beats.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_ld_win) begin
      r_starve_cnt <= '0;
    end else if (ld_valid && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Burst counter: consecutive accepted beats, saturating at MAX_BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (w_ld_win) begin
      if (r_burst_cnt != BW'(MAX_BURST)) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end else begin
      r_burst_cnt <= '0;
    end
  end

  // Read-valid tracks the synchronous RAM latency of one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= cpu_gnt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// cycle-level reference model built from the arbitration rules, with a
// behavioural synchronous RAM attached to the RAM port.
module tb_ram_arbiter;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int SLIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_hlt;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .STARVE_LIM(SLIM)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_hlt(cpu_hlt),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural 16x8 synchronous RAM: write-then-read ordering across cycles.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers and an array)
  int            m_starve   = 0;
  int            m_burst    = 0;
  bit            m_rv       = 1'b0;
  bit            m_rv_known = 1'b0;
  logic [DW-1:0] m_rd       = '0;
  logic [DW-1:0] mem_m [16];

  // Samples of the last cycle for directed checks
  logic          s_gnt, s_ready, s_stall, s_we, s_rvalid;
  logic [DW-1:0] s_rdata;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the negedge, check mid-cycle, update the model
  // at the posedge, return at the next negedge.
  task automatic cycle(input logic r, input logic req, input logic [AW-1:0] a,
                       input logic hlt, input logic lv,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld);
    bit win, gnt;
    rst = r; cpu_req = req; cpu_addr = a; cpu_hlt = hlt;
    ld_valid = lv; ld_addr = la; ld_data = ld;
    #1;
    win = lv && !r && (!req || hlt || m_starve >= SLIM ||
                       (m_burst > 0 && m_burst < MAXB));
    gnt = req && !win && !r;
    check("ld_ready",  ld_ready,  win);
    check("cpu_gnt",   cpu_gnt,   gnt);
    check("cpu_stall", cpu_stall, req && !gnt);
    check("ram_we",    ram_we,    win);
    check("ram_addr",  ram_addr,  win ? la : a);
    check("ram_wdata", ram_wdata, win ? ld : '0);
    if (m_rv_known) check("cpu_rvalid", cpu_rvalid, m_rv);
    if (m_rv_known && m_rv) check("cpu_rdata", cpu_rdata, m_rd);
    s_gnt = cpu_gnt; s_ready = ld_ready; s_stall = cpu_stall; s_we = ram_we;
    s_rvalid = cpu_rvalid; s_rdata = cpu_rdata;
    @(posedge clk);
    if (r) begin
      m_starve = 0; m_burst = 0; m_rv = 1'b0; m_rv_known = 1'b1;
    end else begin
      m_rv = gnt;
      if (gnt) m_rd = mem_m[a];
      if (win) begin
        mem_m[la] = ld;
        m_starve  = 0;
        m_burst   = (m_burst < MAXB) ? m_burst + 1 : MAXB;
      end else begin
        m_burst = 0;
        if (lv) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    bit p_valid;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    @(negedge clk);

    // Reset with a beat presented: it must not be accepted
    cycle(1, 0, 0, 0, 1, 4'h3, 8'hEE);
    check("rst_no_ready", s_ready, 1'b0);
    cycle(1, 1, 0, 0, 1, 4'h3, 8'hEE);
    check("rst_no_gnt", s_gnt, 1'b0);
    check("rst_no_we", s_we, 1'b0);

    // Clear the whole RAM through the loader so the model is fully known
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 1, i[AW-1:0], 8'h00);

    // Loader-only back-to-back beats
    cycle(0, 0, 0, 0, 1, 4'h0, 8'h0A); check("ld0_ready", s_ready, 1'b1);
    cycle(0, 0, 0, 0, 1, 4'h1, 8'h1B); check("ld1_ready", s_ready, 1'b1);
    cycle(0, 0, 0, 0, 1, 4'h2, 8'h2C); check("ld2_ready", s_ready, 1'b1);

    // CPU-only read of RAM[5]=0x33
    cycle(0, 0, 0, 0, 1, 4'h5, 8'h33);
    cycle(0, 1, 4'h5, 0, 0, 0, 0);
    check("rd_gnt", s_gnt, 1'b1);
    check("rd_stall", s_stall, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("rd_rvalid", s_rvalid, 1'b1);
    check("rd_rdata", s_rdata, 8'h33);

    // Contention from reset: CPU x3 then loader x4, repeating
    cycle(1, 0, 0, 0, 0, 0, 0);
    k = 0;
    for (int c = 0; c < 14; c++) begin
      cycle(0, 1, c[AW-1:0], 0, 1, k[AW-1:0], k[DW-1:0] + 8'h40);
      check("cont_ready", s_ready, (c % 7) >= 3);
      check("cont_stall", s_stall, (c % 7) >= 3);
      if (s_ready) k++;
    end

    // Reset in the middle of a burst (contention cycle 5)
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) cycle(0, 1, 4'h1, 0, 1, 4'h9, 8'h99);
    cycle(1, 1, 4'h1, 0, 1, 4'h9, 8'h99);
    check("mid_rst_ready", s_ready, 1'b0);
    check("mid_rst_gnt", s_gnt, 1'b0);
    check("mid_rst_we", s_we, 1'b0);
    cycle(0, 1, 4'h1, 0, 1, 4'h9, 8'h99);
    check("post_rst_cpu_wins", s_gnt, 1'b1);
    check("post_rst_ld_denied", s_ready, 1'b0);

    // Halted CPU: loader owns the RAM with no burst limit
    for (int c = 0; c < 10; c++) begin
      cycle(0, 1, 4'h2, 1, 1, c[AW-1:0], 8'hA0 + c[DW-1:0]);
      check("hlt_ready", s_ready, 1'b1);
      check("hlt_gnt", s_gnt, 1'b0);
      check("hlt_stall", s_stall, 1'b1);
    end

    // Write then read of the same address on consecutive cycles
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 4'h7, 8'h5E);
    cycle(0, 1, 4'h7, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("wr_rd_rvalid", s_rvalid, 1'b1);
    check("wr_rd_rdata", s_rdata, 8'h5E);

    // Randomized traffic; a denied beat is held stable
    p_valid = 1'b0; p_addr = '0; p_data = '0;
    for (int c = 0; c < 500; c++) begin
      logic r, req, hlt;
      logic [AW-1:0] a;
      r   = ($urandom_range(0, 49) == 0);
      req = ($urandom_range(0, 3) != 0);
      hlt = ($urandom_range(0, 9) == 0);
      a   = AW'($urandom);
      if (!p_valid) begin
        p_valid = ($urandom_range(0, 2) != 0);
        p_addr  = AW'($urandom);
        p_data  = DW'($urandom);
      end
      cycle(r, req, a, hlt, p_valid, p_addr, p_data);
      if (s_ready) p_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 16x8 program/data RAM between two masters: the CPU (driven by the microcode sequencer's MEM_LOAD/MEM_EN timing) and a program loader that writes bytes over a valid/ready handshake.
- The CPU has fixed priority. A starvation limit and a bounded loader burst guarantee forward progress for both masters.
- While the CPU is halted, the loader owns the RAM outright.
- Sits between the controller, the RAM, and the external program-load interface.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, maximum consecutive loader beats granted while the CPU is requesting.
- STARVE_LIM, 3, consecutive denied loader cycles after which the loader preempts the CPU.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU requests a RAM read this cycle.
- cpu_addr  input  ADDR_W  CPU read address.
- cpu_hlt  input  1  CPU halted (controller HLT signal).
- cpu_gnt  output  1  CPU owns RAM this cycle (combinational).
- cpu_stall  output  1  cpu_req & ~cpu_gnt; holds the sequencer stage.
- cpu_rvalid  output  1  cpu_rdata valid; registered, one cycle after cpu_gnt.
- cpu_rdata  output  DATA_W  read data, equal to ram_rdata.
- ld_valid  input  1  loader write beat presented.
- ld_addr  input  ADDR_W  loader write address.
- ld_data  input  DATA_W  loader write data.
- ld_ready  output  1  beat accepted this cycle (combinational).
- ram_addr  output  ADDR_W  RAM address.
- ram_we  output  1  RAM write enable.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  synchronous RAM read data, one cycle after address.

Behaviour:
- State registers:
  - starve_cnt: 0..STARVE_LIM, saturating.
  - burst_cnt: 0..MAX_BURST.
  - cpu_rvalid flop.
- Loader win condition, evaluated every cycle:
  - ld_win = ld_valid & ~rst & (~cpu_req | cpu_hlt | starve_cnt==STARVE_LIM | (burst_cnt!=0 & burst_cnt<MAX_BURST)).
- Grants:
  - ld_ready = ld_win.
  - cpu_gnt = cpu_req & ~ld_win & ~rst.
  - At most one grant per cycle.
- RAM mux:
  - ld_win: ram_addr=ld_addr, ram_we=1, ram_wdata=ld_data.
  - Otherwise: ram_addr=cpu_addr, ram_we=0, ram_wdata=0.
- starve_cnt update:
  - Cleared on ld_ready.
  - Incremented (saturating) when ld_valid & ~ld_ready.
  - Unchanged when ld_valid=0.
- burst_cnt update:
  - Incremented (saturating at MAX_BURST) on ld_ready.
  - Cleared on any cycle without ld_ready.
- Effective ownership states: IDLE (no grant), CPU, LD_BURST (burst_cnt>0).
  - LD_BURST→CPU once burst_cnt==MAX_BURST and cpu_req=1.
  - The CPU then receives at least one grant.
- cpu_hlt=1:
  - Loader wins whenever ld_valid, with no burst limit.
  - cpu_gnt=0 if the loader is active.
- cpu_rvalid:
  - Next cycle equals cpu_gnt.
  - cpu_rdata = ram_rdata passthrough; only meaningful while cpu_rvalid=1.
- Same address, write then read:
  - Loader write in cycle N, CPU read of same address in N+1 returns the new data.
  - The RAM guarantees write-then-read ordering.
- Reset (any cycle, including mid-burst):
  - During rst: cpu_gnt=0, ld_ready=0, ram_we=0.
  - Next cycle: starve_cnt=0, burst_cnt=0, cpu_rvalid=0.
  - A beat presented during rst is not accepted; the loader holds it.
- Loader contract: holds ld_addr/ld_data stable while ld_valid & ~ld_ready.

Test Plan:
- Loader-only writes: cpu_req=0, beats (0,0x0A),(1,0x1B),(2,0x2C) back-to-back → ld_ready=1 three cycles; ram_we/addr/wdata match each beat.
- CPU-only read: RAM[5]=0x33, cpu_req=1, cpu_addr=5 for one cycle → cpu_gnt=1 same cycle; cpu_rvalid=1, cpu_rdata=0x33 next cycle; cpu_stall=0.
- Contention with defaults: cpu_req=1 and ld_valid=1 continuously from reset → grants repeat CPU×3 then loader×4 (cycles 0-2 CPU, 3-6 loader, 7-9 CPU, 10-13 loader); cpu_stall=1 exactly in loader cycles.
- Halted CPU: cpu_hlt=1, cpu_req=1, ld_valid=1 for 10 cycles → ld_ready=1 all 10; cpu_gnt=0; cpu_stall=1.
- Reset mid-burst: assert rst at contention cycle 5 for one cycle → that cycle no grant, no write; next cycle with both requesting, CPU wins (counters zero).
- Write-then-read: loader writes (7,0x5E) in cycle N, CPU reads addr 7 in N+1 → cpu_rdata=0x5E with cpu_rvalid in N+2.
